rom_streamer: RTL and testbench

//  Sequencer directly downstream of the synchronous ROM (1-cycle registered read).
//  On a start command, it drives ROM addresses start_addr .. start_addr+length-1.
//  It delivers the returned words as a valid/ready byte stream to the UPDI transmit path.
//  A small prefetch buffer absorbs the ROM read latency, so a ready sink gets one word per cycle.

---
 rtl/rom_streamer_pkg.sv | 17 +
 rtl/stream_fifo2.sv | 87 ++++++++
 rtl/rom_streamer.sv | 150 +++++++++++++++
 tb/tb_rom_streamer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_streamer_pkg.sv
// ---------------------------------------------------------------------------
// rom_stream_pkg
// Shared types and constants for the ROM streamer.
//   rs_state_t      : sequencer state (IDLE -> RUN -> DONE -> IDLE)
//   PREFETCH_DEPTH  : number of words the prefetch buffer can hold
// ---------------------------------------------------------------------------
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rs_state_t;

    localparam int PREFETCH_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// ---------------------------------------------------------------------------
// stream_fifo2
// Two-entry FIFO that buffers ROM words ahead of the output stream.
// The head entry is always presented on pop_data, so the stream data comes
// straight from a flop.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the FIFO (takes priority over push/pop)
//   push        : write push_data at the tail
//   push_data   : word to write
//   pop         : remove the head entry (ignored when empty)
//   pop_data    : current head entry
//   count       : number of valid entries (0..2)
// ---------------------------------------------------------------------------
module stream_fifo2 #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] pop_data,
    output logic [1:0]           count
);

    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] tail_q, tail_d;
    logic [1:0]           count_q, count_d;
    logic                 pop_ok;

    // A pop on an empty FIFO is meaningless; mask it so the count cannot wrap.
    assign pop_ok = pop && (count_q != 2'd0);

    // Entries shift from tail to head on a pop, so the head register is always
    // the oldest word.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_data;
                    end else begin
                        tail_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = push_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign pop_data = head_q;
    assign count    = count_q;

endmodule

// File: rtl/rom_streamer.sv
// ---------------------------------------------------------------------------
// rom_streamer
// Reads start_addr .. start_addr+length-1 from a synchronous ROM (1-cycle
// registered read) and emits the words as a valid/ready stream. A 2-entry
// prefetch buffer hides the ROM latency so a ready sink gets one word/cycle.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, start_addr,
//   length               : transfer command, accepted only in IDLE
//   abort                : cancel the current transfer (no done pulse)
//   busy, done           : busy while running, done pulses for one cycle
//   rom_addr / rom_data  : ROM read port (address registered)
//   out_data, out_valid,
//   out_ready            : output byte stream
// ---------------------------------------------------------------------------
module rom_streamer
    import rom_stream_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10,
    parameter int LEN_BITS  = ADDR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [LEN_BITS-1:0]  length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [DATA_BITS-1:0] rom_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    rs_state_t             state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [LEN_BITS-1:0]   length_q, length_d;
    logic [LEN_BITS-1:0]   remaining_q, remaining_d;
    logic [LEN_BITS-1:0]   issued_q, issued_d;
    logic                  inflight_q, inflight_d;

    logic                  handshake;
    logic                  issue;
    logic                  flush;
    logic [1:0]            buf_count;
    logic [1:0]            count_after_pop;
    logic [2:0]            credit_used;

    assign handshake = out_valid && out_ready;

    // The pop happening this cycle is certain, so it frees its slot for the
    // credit check right away; without that, a ready sink would only see two
    // words every three cycles. The buffer still cannot overflow: whatever
    // is issued now lands one cycle after the current in-flight word.
    assign count_after_pop = buf_count - {1'b0, handshake};
    assign credit_used     = {1'b0, count_after_pop} + {2'b00, inflight_q};

    // The address register drives the ROM directly; an issue in this cycle
    // means the ROM captures addr_q at the coming edge.
    assign issue = (state_q == RUN) && !abort && (issued_q < length_q) &&
                   (credit_used < 3'(PREFETCH_DEPTH));

    assign flush = (state_q == RUN) && abort;

    // Sequencer: command capture, read issue accounting and completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        length_d    = length_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        inflight_d  = issue;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    addr_d      = start_addr;
                    length_d    = length;
                    remaining_d = length;
                    issued_d    = '0;
                    state_d     = (length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    inflight_d = 1'b0;
                end else begin
                    if (issue) begin
                        addr_d   = addr_q + ADDR_BITS'(1);
                        issued_d = issued_q + LEN_BITS'(1);
                    end
                    if (handshake) begin
                        remaining_d = remaining_q - LEN_BITS'(1);
                        if (remaining_q == LEN_BITS'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            length_q    <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            length_q    <= length_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
        end
    end

    // The word requested last cycle is on rom_data now; capture it unless the
    // transfer is being cancelled.
    stream_fifo2 #(
        .DATA_BITS (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (rom_data),
        .pop       (handshake),
        .pop_data  (out_data),
        .count     (buf_count)
    );

    assign out_valid = (buf_count != 2'd0);
    assign rom_addr  = addr_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rom_streamer.sv
// ---------------------------------------------------------------------------
// tb_rom_streamer
// Directed bench for rom_streamer. The ROM model returns data[i] = i[7:0]
// one cycle after the address is presented.
// ---------------------------------------------------------------------------
module tb_rom_streamer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int failures;

    rom_streamer #(
        .DATA_BITS (8),
        .ADDR_BITS (10),
        .LEN_BITS  (11)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Clock generation, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: data[i] = i.
    always @(posedge clk) begin
        rom_data <= rom_addr[7:0];
    end

    // Advance to just after the next rising edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Drive a start command for one cycle (cycle 0), sample after it.
    task automatic issue_start(input logic [9:0] a, input logic [10:0] len, input logic rdy);
        next_cycle;
        start      = 1'b1;
        start_addr = a;
        length     = len;
        out_ready  = rdy;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got busy/done/valid=%b expected 000", {busy, done, out_valid});
        end
        checks++;
        if (rom_addr !== 10'h000 || out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_data: got rom_addr=%h out_data=%h expected 000/00", rom_addr, out_data);
        end
        next_cycle;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_release: got busy/done/valid=%b expected 000", {busy, done, out_valid});
        end
    endtask

    task automatic test_basic;
        logic       exp_valid;
        logic       exp_done;
        logic       exp_busy;
        logic [7:0] exp_data;
        issue_start(10'h010, 11'd4, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            next_cycle;
            start = 1'b0;
            @(negedge clk);
            exp_valid = (c >= 3) && (c <= 6);
            exp_busy  = (c >= 1) && (c <= 6);
            exp_done  = (c == 7);
            exp_data  = 8'(8'h10 + c - 3);
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("[TB] FAIL basic_valid c%0d: got %b expected %b", c, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_data) begin
                    failures++;
                    $display("[TB] FAIL basic_data c%0d: got %h expected %h", c, out_data, exp_data);
                end
            end
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                failures++;
                $display("[TB] FAIL basic_status c%0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, busy, done, exp_busy, exp_done);
            end
            if (c == 1) begin
                checks++;
                if (rom_addr !== 10'h010) begin
                    failures++;
                    $display("[TB] FAIL basic_rom_addr: got %h expected 010", rom_addr);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic       pat [4];
        int         got;
        logic       seen_done;
        logic       prev_stall;
        logic [7:0] prev_data;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        got        = 0;
        seen_done  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        issue_start(10'h010, 11'd4, pat[0]);
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            next_cycle;
            start     = 1'b0;
            out_ready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("[TB] FAIL bp_stable c%0d: got valid=%b data=%h expected 1/%h",
                             c, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 8'(8'h10 + got)) begin
                    failures++;
                    $display("[TB] FAIL bp_order word%0d: got %h expected %h", got, out_data, 8'(8'h10 + got));
                end
                got++;
            end
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (got != 4) begin
                    failures++;
                    $display("[TB] FAIL bp_count: got %0d words expected 4", got);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("[TB] FAIL bp_timeout: got no done within 40 cycles expected done");
        end
        out_ready = 1'b1;
        next_cycle;
    endtask

    task automatic test_wrap;
        logic [7:0] exp_words [3];
        exp_words[0] = 8'hFF; exp_words[1] = 8'h00; exp_words[2] = 8'h01;
        issue_start(10'h3FF, 11'd3, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            next_cycle;
            start = 1'b0;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (rom_addr !== 10'h000) begin
                    failures++;
                    $display("[TB] FAIL wrap_rom_addr: got %h expected 000", rom_addr);
                end
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_words[c-3]) begin
                    failures++;
                    $display("[TB] FAIL wrap_data c%0d: got valid=%b data=%h expected 1/%h",
                             c, out_valid, out_data, exp_words[c-3]);
                end
            end
            if (c == 6) begin
                checks++;
                if (done !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL wrap_done: got done=%b valid=%b expected 1/0", done, out_valid);
                end
            end
        end
    endtask

    task automatic test_zero_length;
        issue_start(10'h123, 11'd0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== (c == 1) || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL zero_len c%0d: got done=%b busy=%b valid=%b expected %b/0/0",
                         c, done, busy, out_valid, (c == 1));
            end
        end
    endtask

    task automatic test_abort;
        issue_start(10'h020, 11'd8, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle;
            start = 1'b0;
            @(negedge clk);
        end
        next_cycle;
        abort     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            failures++;
            $display("[TB] FAIL abort_pre: got valid=%b data=%h expected 1/22", out_valid, out_data);
        end
        for (int c = 6; c <= 10; c++) begin
            next_cycle;
            abort     = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_post c%0d: got valid=%b busy=%b done=%b expected 000",
                         c, out_valid, busy, done);
            end
        end
        // start and abort together in IDLE: the command must be dropped
        next_cycle;
        start      = 1'b1;
        abort      = 1'b1;
        start_addr = 10'h040;
        length     = 11'd2;
        next_cycle;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_start_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
        // a fresh transfer works from its first cycle
        issue_start(10'h040, 11'd2, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            next_cycle;
            start = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (rom_addr !== 10'h040 || busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL restart_c1: got rom_addr=%h busy=%b expected 040/1", rom_addr, busy);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'(8'h40 + c - 3)) begin
                    failures++;
                    $display("[TB] FAIL restart_data c%0d: got valid=%b data=%h expected 1/%h",
                             c, out_valid, out_data, 8'(8'h40 + c - 3));
                end
            end
            if (c == 5) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL restart_done: got %b expected 1", done);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        issue_start(10'h050, 11'd8, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle;
            start      = 1'b1;
            start_addr = 10'h070;
            length     = 11'd1;
            @(negedge clk);
        end
        checks++;
        if (rom_addr !== 10'h052 || out_valid !== 1'b1 || out_data !== 8'h50 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_while_busy: got rom_addr=%h valid=%b data=%h busy=%b expected 052/1/50/1",
                     rom_addr, out_valid, out_data, busy);
        end
        next_cycle;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || rom_addr !== 10'h000 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid: got valid=%b data=%h rom_addr=%h busy=%b done=%b expected all 0",
                     out_valid, out_data, rom_addr, busy, done);
        end
        start = 1'b0;
        next_cycle;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_mid_after c%0d: got valid=%b busy=%b done=%b expected 000",
                         c, out_valid, busy, done);
            end
            next_cycle;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_zero_length;
        test_abort;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
